flash_reader: RTL and testbench
===============================

FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 Parameter FMT, default 3'b001, bus format driven on format while CS# is low (SDR).
REQ-002 Parameter PRESC, default 4'd2, constant value driven on prescale.
REQ-003 Parameter WHO_ID, default 1'b0, constant value driven on who.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  system clock
- arstn  in  1  async reset, active low
- req_valid  in  1  read request present
- req_ready  out  1  sequencer idle, request accepted when req_valid & req_ready
- req_addr  in  24  flash byte address
- req_len  in  16  byte count, 0 permitted
- abort  in  1  terminate current transfer
- out_valid  out  1  out_data holds a read byte
- out_ready  in  1  consumer accepts byte
- out_data  out  8  read byte
- out_last  out  1  final byte of request, qualified by out_valid
- done  out  1  one-cycle pulse when CS# released
- f_ready  in  1  flash port ready for next byte
- f_wr  out  1  flash transmit strobe, one-cycle pulse
- f_who  out  1  requester id, equals WHO_ID
- f_dout  out  8  byte to flash
- f_format  out  3  000 = CS# high, FMT = active
- f_prescale  out  4  equals PRESC
- f_din  in  8  byte from flash

Function
REQ-005 States: IDLE, CMD, A2, A1, A0, DUMMY, RD, CAP, HOLD, END, FIN.
REQ-006 f_wr SHALL assert only in a cycle where f_ready=1, and SHALL never assert on two consecutive cycles.
REQ-007 After each f_wr, the sequencer SHALL ignore f_ready for one cycle, then wait for f_ready=1.
REQ-008 IDLE: req_ready=1, f_format=000; on accept, latch addr and len and go to CMD; if len=0, go to FIN instead with no f_wr.
REQ-009 CMD/A2/A1/A0/DUMMY SHALL each issue one f_wr carrying, in order: 8'h0B, addr[23:16], addr[15:8], addr[7:0], 8'h00, with f_format=FMT.
REQ-010 RD: issue f_wr (f_dout=8'hFF, f_format=FMT), then go to CAP.
REQ-011 CAP: on first f_ready=1 after the strobe, register f_din into out_data, set out_valid, and go to HOLD.
REQ-012 out_last SHALL be 1 when the remaining count equals 1.
REQ-013 HOLD: out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 HOLD: on out_ready, decrement the 16-bit remaining count; go to RD if it is nonzero, else to END.
REQ-015 END: when f_ready=1, issue f_wr with f_format=000 and f_dout=8'hFF, then go to FIN.
REQ-016 FIN: pulse done for one cycle, then return to IDLE.
REQ-017 A byte-count decrement SHALL never underflow.
REQ-018 The address SHALL NOT be incremented internally; the flash auto-increments.
REQ-019 abort in any state from CMD to HOLD: drop out_valid and go to END (CS# released, done pulsed).
REQ-020 abort in IDLE, END or FIN SHALL be ignored.
REQ-021 If abort and out_ready are both asserted in HOLD, the byte SHALL count as consumed and the sequence SHALL go to END.
REQ-022 req_valid outside IDLE SHALL be ignored (req_ready=0).
REQ-023 Latency from accept to first f_wr SHALL be 1 cycle when f_ready=1.

Reset
REQ-024 While arstn=0: state=IDLE, req_ready=0, f_wr=0, f_format=000, f_dout=8'h00, out_valid=0, out_data=8'h00, out_last=0, done=0, count=0.
REQ-025 req_ready SHALL rise on the first clock after arstn deasserts.
REQ-026 Reset mid-transfer SHALL force f_format=000 immediately and asynchronously.
REQ-027 f_who and f_prescale SHALL be constant and unaffected by reset.

Structure
REQ-028 Shared package SHALL hold the state encoding, the opcode constant 8'h0B, the format constants FMT_OFF=3'b000 and FMT_SDR=3'b001, and the filler bytes 8'h00 and 8'hFF.
REQ-029 Natural sub-module: flash_reader_ctl (FSM plus count), with the top level adding only the output registers; a single module is also acceptable.

Verification
REQ-030 Bench SHALL use the team flash simulation model with file bytes 00..FF repeating.
REQ-031 Directed scenarios:
- addr=0x000010, len=4, out_ready=1 -> bytes 10,11,12,13; out_last on 13; exactly 9 f_wr; done once.
- addr=0x0000FE, len=3, out_ready toggling 1/0 -> bytes FE,FF,00 with no loss or duplication; data held stable while stalled.
- len=0 -> no f_wr; done 2 cycles after accept; req_ready back 1 cycle later.
- abort asserted during the 2nd data byte, len=8 -> out_valid drops; an END f_wr with format 000 follows; done pulses; next request reads correctly.
- arstn low during A1 -> f_format=000 immediately; after release, addr=0x000020, len=1 returns 20.
- Throughout all scenarios, an assertion SHALL check that no f_wr occurs while f_ready=0; the model must report no write-to-not-ready error.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// Shared definitions for the serial-flash fast-read sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flash_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_A2,
        ST_A1,
        ST_A0,
        ST_DUMMY,
        ST_RD,
        ST_CAP,
        ST_HOLD,
        ST_END,
        ST_FIN
    } state_t;

    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam logic [2:0] FMT_OFF       = 3'b000;
    localparam logic [2:0] FMT_SDR       = 3'b001;
    localparam logic [7:0] FILL_00       = 8'h00;
    localparam logic [7:0] FILL_FF       = 8'hFF;

    // Byte-count decrement that sticks at zero instead of wrapping.
    function automatic logic [15:0] dec_sat(input logic [15:0] v);
        return (v == 16'd0) ? 16'd0 : v - 16'd1;
    endfunction

endpackage

// File: rtl/flash_reader_ctl.sv
// Sequencer FSM: issues opcode/address/dummy/read strobes to the flash port and tracks the byte count.
// Latency: first flash strobe one clock after request accept when the port is ready.
// Backpressure: waits on f_ready (ignored for one cycle after each strobe) and on out_ready in HOLD.
module flash_reader_ctl
    import flash_reader_pkg::*;
#(
    parameter logic [2:0] FMT = FMT_SDR
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    input  logic        abort,
    input  logic        out_ready,
    input  logic        f_ready,
    output logic        f_wr,
    output logic [7:0]  f_dout,
    output logic [2:0]  f_format,
    output logic        done,
    output logic        cap_en,
    output logic        cap_last,
    output logic        rel_en
);

    state_t      state;
    logic [23:0] addr;
    logic [15:0] count;
    logic        flash_go;

    // A strobe was issued last cycle while f_wr is high, so f_ready is not trusted until it drops.
    always_comb begin
        flash_go = f_ready && !f_wr;
        cap_en   = (state == ST_CAP) && flash_go && !abort;
        cap_last = (count == 16'd1);
        rel_en   = (state == ST_HOLD) && (out_ready || abort);
    end

    // Main sequencer with registered flash-side outputs; CS# is active whenever f_format is non-zero.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            f_wr      <= 1'b0;
            f_dout    <= FILL_00;
            f_format  <= FMT_OFF;
            done      <= 1'b0;
            count     <= 16'd0;
            addr      <= 24'd0;
        end else begin
            f_wr <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr      <= req_addr;
                        count     <= req_len;
                        if (req_len == 16'd0) begin
                            state <= ST_FIN;
                        end else begin
                            state    <= ST_CMD;
                            f_format <= FMT;
                        end
                    end
                end
                ST_CMD: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= OPC_FAST_READ;
                        state  <= ST_A2;
                    end
                end
                ST_A2: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= addr[23:16];
                        state  <= ST_A1;
                    end
                end
                ST_A1: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= addr[15:8];
                        state  <= ST_A0;
                    end
                end
                ST_A0: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= addr[7:0];
                        state  <= ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= FILL_00;
                        state  <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) begin
                        f_wr   <= 1'b1;
                        f_dout <= FILL_FF;
                        state  <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    if (abort) state <= ST_END;
                    else if (flash_go) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // A byte taken in the same cycle as abort still counts as consumed.
                    if (out_ready) count <= dec_sat(count);
                    if (abort) state <= ST_END;
                    else if (out_ready) state <= (dec_sat(count) != 16'd0) ? ST_RD : ST_END;
                end
                ST_END: begin
                    if (flash_go) begin
                        f_wr     <= 1'b1;
                        f_dout   <= FILL_FF;
                        f_format <= FMT_OFF;
                        state    <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_reader.sv
// Serial-flash fast-read engine: turns {addr,len} requests into a byte stream on a valid/ready port.
// Latency: first flash strobe one clock after accept; each byte appears one clock after the flash returns it.
// Backpressure: out_ready low holds the byte and stalls the sequencer; f_ready low stalls flash strobes.
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter logic [2:0] FMT    = FMT_SDR,
    parameter logic [3:0] PRESC  = 4'd2,
    parameter logic       WHO_ID = 1'b0
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done,
    input  logic        f_ready,
    output logic        f_wr,
    output logic        f_who,
    output logic [7:0]  f_dout,
    output logic [2:0]  f_format,
    output logic [3:0]  f_prescale,
    input  logic [7:0]  f_din
);

    logic cap_en;
    logic cap_last;
    logic rel_en;

    flash_reader_ctl #(
        .FMT(FMT)
    ) u_ctl (
        .clk       (clk),
        .arstn     (arstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .abort     (abort),
        .out_ready (out_ready),
        .f_ready   (f_ready),
        .f_wr      (f_wr),
        .f_dout    (f_dout),
        .f_format  (f_format),
        .done      (done),
        .cap_en    (cap_en),
        .cap_last  (cap_last),
        .rel_en    (rel_en)
    );

    assign f_who      = WHO_ID;
    assign f_prescale = PRESC;

    // Read-byte holding register: loaded on capture, held untouched until consumed or aborted.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            out_valid <= 1'b0;
            out_data  <= FILL_00;
            out_last  <= 1'b0;
        end else if (cap_en) begin
            out_valid <= 1'b1;
            out_data  <= f_din;
            out_last  <= cap_last;
        end else if (rel_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_reader.sv
module tb_flash_reader;

    localparam logic [2:0] FMT = 3'b001;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'd0;
    logic [15:0] req_len = 16'd0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;
    logic        f_ready = 1'b1;
    logic        f_wr;
    logic        f_who;
    logic [7:0]  f_dout;
    logic [2:0]  f_format;
    logic [3:0]  f_prescale;
    logic [7:0]  f_din = 8'h00;

    logic auto_ready = 1'b1;
    logic man_ready = 1'b0;
    int   mode = 0;    // 0: always ready, 1: toggle, 2: driven by the main sequence
    assign out_ready = (mode == 2) ? man_ready : auto_ready;

    flash_reader #(.FMT(FMT), .PRESC(4'd2), .WHO_ID(1'b0)) dut (
        .clk(clk), .arstn(arstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done),
        .f_ready(f_ready), .f_wr(f_wr), .f_who(f_who), .f_dout(f_dout),
        .f_format(f_format), .f_prescale(f_prescale), .f_din(f_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash model: byte at address a is a[7:0]; auto-increments while CS# stays low.
    int          m_idx = 0;
    logic [1:0]  m_busy = 2'd0;
    logic [23:0] m_addr = 24'd0;
    logic [23:0] m_ptr = 24'd0;
    logic [7:0]  m_cmd = 8'h00;
    int          m_bad = 0;
    int          m_wr_err = 0;

    always @(posedge clk) begin
        if (f_wr) begin
            if (!f_ready) m_wr_err++;
            f_ready <= 1'b0;
            m_busy  <= 2'd2;
            if (f_format == 3'b000) begin
                m_idx <= 0;
            end else begin
                if (f_format != FMT) m_bad++;
                m_idx <= m_idx + 1;
                case (m_idx)
                    0: m_cmd <= f_dout;
                    1: m_addr[23:16] <= f_dout;
                    2: m_addr[15:8] <= f_dout;
                    3: begin
                        m_addr[7:0] <= f_dout;
                        m_ptr <= {m_addr[23:8], f_dout};
                    end
                    4: if (f_dout != 8'h00) m_bad++;
                    default: begin
                        if (f_dout != 8'hFF) m_bad++;
                        f_din <= m_ptr[7:0];
                        m_ptr <= m_ptr + 24'd1;
                    end
                endcase
            end
        end else begin
            if (f_format == 3'b000) m_idx <= 0;
            if (m_busy != 2'd0) begin
                m_busy <= m_busy - 2'd1;
                if (m_busy == 2'd1) f_ready <= 1'b1;
            end
        end
    end

    // Consumer, byte monitor and strobe-rule checks, all sampled on the falling edge.
    logic [7:0] got_b[$];
    logic       got_l[$];
    int   act_wr = 0;
    int   end_wr = 0;
    int   done_cnt = 0;
    logic prev_wr = 1'b0;
    logic held_vld = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic held_l = 1'b0;

    always @(negedge clk) begin
        assert (!(f_wr && !f_ready)) else $error("f_wr while f_ready low");
        if (held_vld) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(held_d));
            chk("stall_last", 32'(out_last), 32'(held_l));
            held_vld = 1'b0;
        end
        if (mode == 1) auto_ready = ~auto_ready;
        else auto_ready = 1'b1;
        if (mode != 2 && out_valid) begin
            if (auto_ready) begin
                got_b.push_back(out_data);
                got_l.push_back(out_last);
            end else begin
                held_d = out_data;
                held_l = out_last;
                held_vld = 1'b1;
            end
        end
        if (f_wr) begin
            chk("wr_only_when_ready", 32'(f_ready), 32'd1);
            chk("wr_not_back_to_back", 32'(prev_wr), 32'd0);
            if (f_format == 3'b000) end_wr++;
            else act_wr++;
        end
        prev_wr = f_wr;
        if (done) done_cnt++;
    end

    task automatic start_req(input logic [23:0] a, input logic [15:0] l);
        int n;
        n = 0;
        @(negedge clk);
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        int          cmode;
        logic [31:0] bytes;   // expected bytes, first in [7:0]
        int          act;     // expected strobes with CS# low
    } vec_t;

    vec_t vt[4];

    initial begin
        int b_act, b_end, b_done, n;
        logic [7:0] e;

        vt[0] = '{24'h000010, 16'd4, 0, 32'h13121110, 9};
        vt[1] = '{24'h0000FE, 16'd3, 1, 32'h0000FFFE, 8};
        vt[2] = '{24'h123456, 16'd1, 0, 32'h00000056, 6};
        vt[3] = '{24'h00ABFF, 16'd2, 1, 32'h000000FF, 7};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_f_wr", 32'(f_wr), 32'd0);
        chk("rst_f_format", 32'(f_format), 32'd0);
        chk("rst_f_dout", 32'(f_dout), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_f_who", 32'(f_who), 32'd0);
        chk("rst_f_prescale", 32'(f_prescale), 32'd2);
        arstn = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Zero-length request: no strobes, done two cycles after accept, ready one later
        b_act = act_wr; b_end = end_wr;
        req_addr = 24'h000100; req_len = 16'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("len0_c1_done", 32'(done), 32'd0);
        chk("len0_c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("len0_c2_done", 32'(done), 32'd1);
        chk("len0_c2_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("len0_c3_done", 32'(done), 32'd0);
        chk("len0_c3_ready", 32'(req_ready), 32'd1);
        chk("len0_no_wr", 32'((act_wr - b_act) + (end_wr - b_end)), 32'd0);

        // Abort during the second data byte, with first-strobe latency check
        mode = 2; man_ready = 1'b0;
        b_end = end_wr; b_done = done_cnt;
        start_req(24'h000040, 16'd8);
        chk("lat_c1_wr", 32'(f_wr), 32'd0);
        @(negedge clk);
        chk("lat_c2_wr", 32'(f_wr), 32'd1);
        chk("lat_c2_dout", 32'(f_dout), 32'h0B);
        chk("lat_c2_fmt", 32'(f_format), 32'(FMT));
        wait_valid();
        chk("abort_b0", 32'(out_data), 32'h40);
        chk("abort_b0_last", 32'(out_last), 32'd0);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        chk("abort_b0_taken", 32'(out_valid), 32'd0);
        wait_valid();
        chk("abort_b1", 32'(out_data), 32'h41);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_drop_valid", 32'(out_valid), 32'd0);
        wait_done(b_done);
        chk("abort_end_wr", 32'(end_wr - b_end), 32'd1);
        chk("abort_done_once", 32'(done_cnt - b_done), 32'd1);
        chk("abort_cs_released", 32'(f_format), 32'd0);
        chk("abort_out_valid_idle", 32'(out_valid), 32'd0);
        mode = 0;

        // Table-driven reads
        for (int i = 0; i < 4; i++) begin
            mode = vt[i].cmode;
            got_b.delete();
            got_l.delete();
            b_act = act_wr; b_end = end_wr; b_done = done_cnt;
            start_req(vt[i].addr, vt[i].len);
            wait_done(b_done);
            chk($sformatf("v%0d_nbytes", i), 32'(got_b.size()), 32'(vt[i].len));
            for (int k = 0; k < int'(vt[i].len); k++) begin
                e = vt[i].bytes[8*k +: 8];
                if (k < got_b.size()) begin
                    chk($sformatf("v%0d_byte%0d", i, k), 32'(got_b[k]), 32'(e));
                    chk($sformatf("v%0d_last%0d", i, k), 32'(got_l[k]),
                        (k == int'(vt[i].len) - 1) ? 32'd1 : 32'd0);
                end
            end
            chk($sformatf("v%0d_active_wr", i), 32'(act_wr - b_act), 32'(vt[i].act));
            chk($sformatf("v%0d_end_wr", i), 32'(end_wr - b_end), 32'd1);
            chk($sformatf("v%0d_done_once", i), 32'(done_cnt - b_done), 32'd1);
            chk($sformatf("v%0d_opcode", i), 32'(m_cmd), 32'h0B);
            chk($sformatf("v%0d_flash_addr", i), 32'(m_addr), 32'(vt[i].addr));
        end
        mode = 0;

        // Reset while the sequencer sits in A1
        b_act = act_wr;
        start_req(24'h000030, 16'd4);
        n = 0;
        while ((act_wr - b_act) < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a1_reached", 32'(act_wr - b_act), 32'd2);
        chk("pre_rst_fmt", 32'(f_format), 32'(FMT));
        #2;
        arstn = 1'b0;
        #1;
        chk("rst_async_fmt", 32'(f_format), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd0);
        chk("rst_f_prescale_hold", 32'(f_prescale), 32'd2);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst2", 32'(req_ready), 32'd1);
        got_b.delete();
        got_l.delete();
        b_done = done_cnt;
        start_req(24'h000020, 16'd1);
        wait_done(b_done);
        chk("post_rst_nbytes", 32'(got_b.size()), 32'd1);
        if (got_b.size() > 0) begin
            chk("post_rst_byte", 32'(got_b[0]), 32'h20);
            chk("post_rst_last", 32'(got_l[0]), 32'd1);
        end

        chk("model_wr_not_ready", 32'(m_wr_err), 32'd0);
        chk("model_bad_bytes", 32'(m_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
